hex_display_driver: RTL and testbench

- Downstream consumer of the 32-bit debug display word selected for the board's eight seven-segment digits (HEX7..HEX0).
- Captures the word on a sample strobe and supports freeze.
- Blanks leading zeros.
- Blinks the digits that changed since the previous capture for a bounded time, so single-stepping the processor visibly marks which nibbles moved.
- Drives registered, active-low segment patterns.

---
 rtl/display_pkg.sv | 22 ++
 rtl/hex_to_seven_seg.sv | 11 +
 rtl/hex_display_driver.sv | 167 ++++++++++++++++
 tb/tb_hex_display_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the eight-digit seven-segment display path.
package display_pkg;

    localparam int unsigned NIBBLES = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEG_W   = 7;

    // All segments off (active-low)
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value 0..F
    localparam logic [15:0][SEG_W-1:0] SEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        IDLE      = 1'b0,
        HIGHLIGHT = 1'b1
    } disp_state_e;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seven_seg
    import display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_CODES[nibble];

endmodule

// File: rtl/hex_display_driver.sv
// Captures a 32-bit debug word, blanks leading zeros and blinks the digits
// that changed on the last capture, driving eight registered active-low digits.
module hex_display_driver
    import display_pkg::*;
#(
    parameter int unsigned HIGHLIGHT_CYCLES = 50_000_000,
    parameter int unsigned BLINK_BIT        = 22,
    parameter int unsigned CNT_W            = 26
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Value_In,
    input  logic              Update_Strobe,
    input  logic              Freeze,
    input  logic              Blank_Leading_Zeros,
    output logic [SEG_W-1:0]  HEX0,
    output logic [SEG_W-1:0]  HEX1,
    output logic [SEG_W-1:0]  HEX2,
    output logic [SEG_W-1:0]  HEX3,
    output logic [SEG_W-1:0]  HEX4,
    output logic [SEG_W-1:0]  HEX5,
    output logic [SEG_W-1:0]  HEX6,
    output logic [SEG_W-1:0]  HEX7,
    output logic [NIBBLES-1:0] Change_Mask,
    output logic              Highlight_Active
);

    localparam logic [CNT_W-1:0] TIMER_RELOAD = CNT_W'(HIGHLIGHT_CYCLES - 1);

    disp_state_e                     state;
    disp_state_e                     state_next;
    logic [DATA_W-1:0]               captured;
    logic [DATA_W-1:0]               captured_next;
    logic [NIBBLES-1:0]              change_mask;
    logic [NIBBLES-1:0]              mask_next;
    logic [CNT_W-1:0]                timer;
    logic [CNT_W-1:0]                timer_next;
    logic [CNT_W-1:0]                blink_cnt;
    logic                            capture_c;
    logic [NIBBLES-1:0]              diff_c;
    logic [2:0]                      msd_c;
    logic [NIBBLES-1:0][SEG_W-1:0]   enc_c;
    logic [NIBBLES-1:0][SEG_W-1:0]   seg_next;
    logic [NIBBLES-1:0][SEG_W-1:0]   hex_q;
    logic                            unused_cnt_bits_c;

    assign capture_c = Update_Strobe & ~Freeze;

    // Only the blink phase bit of the free-running counter is observed
    assign unused_cnt_bits_c = ^blink_cnt;

    // One decoder per digit, fed from the captured word
    for (genvar k = 0; k < NIBBLES; k++) begin : g_dec
        hex_to_seven_seg u_dec (
            .nibble (captured[4*k +: 4]),
            .seg_c  (enc_c[k])
        );
    end

    // Per-nibble difference between the incoming word and the held word
    always_comb begin
        diff_c = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            diff_c[k] = (Value_In[4*k +: 4] != captured[4*k +: 4]);
        end
    end

    // Most significant nonzero nibble of the held word (0 when all zero)
    always_comb begin
        msd_c = '0;
        for (int k = 1; k < NIBBLES; k++) begin
            if (captured[4*k +: 4] != 4'h0) begin
                msd_c = 3'(k);
            end
        end
    end

    // Next state: capture, highlight mask and timer; a capture beats expiry
    always_comb begin
        state_next    = state;
        mask_next     = change_mask;
        timer_next    = timer;
        captured_next = captured;

        if (capture_c) begin
            captured_next = Value_In;
        end

        case (state)
            IDLE: begin
                if (capture_c && (diff_c != '0)) begin
                    state_next = HIGHLIGHT;
                    mask_next  = diff_c;
                    timer_next = TIMER_RELOAD;
                end
            end
            HIGHLIGHT: begin
                if (capture_c && (diff_c != '0)) begin
                    mask_next  = diff_c;
                    timer_next = TIMER_RELOAD;
                end else if (timer == '0) begin
                    state_next = IDLE;
                    mask_next  = '0;
                end else begin
                    timer_next = timer - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
                timer_next = '0;
            end
        endcase
    end

    // Segment patterns after leading-zero blanking and blink darkening
    always_comb begin
        seg_next = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if ((change_mask[k] && blink_cnt[BLINK_BIT] && (state == HIGHLIGHT)) ||
                (Blank_Leading_Zeros && (3'(k) > msd_c))) begin
                seg_next[k] = SEG_BLANK;
            end else begin
                seg_next[k] = enc_c[k];
            end
        end
    end

    // State register: FSM, captured word, mask, timer and blink counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            captured         <= '0;
            change_mask      <= '0;
            timer            <= '0;
            blink_cnt        <= '0;
            Highlight_Active <= 1'b0;
        end else begin
            state            <= state_next;
            captured         <= captured_next;
            change_mask      <= mask_next;
            timer            <= timer_next;
            blink_cnt        <= blink_cnt + CNT_W'(1);
            Highlight_Active <= (state_next == HIGHLIGHT);
        end
    end

    // Registered segment outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hex_q <= {NIBBLES{SEG_BLANK}};
        end else begin
            hex_q <= seg_next;
        end
    end

    assign Change_Mask = change_mask;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed, table-driven bench for hex_display_driver with short highlight timing.
module tb_hex_display_driver;

    localparam int unsigned HC = 8;
    localparam int unsigned BB = 1;
    localparam int unsigned CW = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Value_In = '0;
    logic        Update_Strobe = 1'b0;
    logic        Freeze = 1'b0;
    logic        Blank_Leading_Zeros = 1'b0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [7:0]  Change_Mask;
    logic        Highlight_Active;

    logic [55:0] hex_all;
    logic [3:0]  bc;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [31:0] value;
        logic        blank;
        logic        freeze;
        logic [7:0]  mask;
        logic        active;
        logic [55:0] hex;
    } vec_t;

    vec_t vecs[13];

    always #5 Clock = ~Clock;

    hex_display_driver #(
        .HIGHLIGHT_CYCLES (HC),
        .BLINK_BIT        (BB),
        .CNT_W            (CW)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .Value_In            (Value_In),
        .Update_Strobe       (Update_Strobe),
        .Freeze              (Freeze),
        .Blank_Leading_Zeros (Blank_Leading_Zeros),
        .HEX0                (HEX0),
        .HEX1                (HEX1),
        .HEX2                (HEX2),
        .HEX3                (HEX3),
        .HEX4                (HEX4),
        .HEX5                (HEX5),
        .HEX6                (HEX6),
        .HEX7                (HEX7),
        .Change_Mask         (Change_Mask),
        .Highlight_Active    (Highlight_Active)
    );

    assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    // Reference copy of the free-running blink counter
    always @(posedge Clock or posedge Reset) begin
        if (Reset) bc <= '0;
        else       bc <= bc + 4'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    // Expected digits with the blink overlay used by the most recent edge
    function automatic logic [55:0] blink(input logic [55:0] lit, input logic [7:0] mask,
                                          input logic hl);
        logic [3:0]  t;
        logic [55:0] r;
        t = bc - 4'd1;
        r = lit;
        for (int k = 0; k < 8; k++) begin
            if (hl && mask[k] && t[BB]) r[7*k +: 7] = 7'h7F;
        end
        return r;
    endfunction

    task automatic strobe(input logic [31:0] v);
        Value_In      = v;
        Update_Strobe = 1'b1;
        step();
        Update_Strobe = 1'b0;
    endtask

    // Capture v and follow the whole highlight window cycle by cycle
    task automatic window(input logic [31:0] v, input logic [7:0] m, input logic [55:0] lit,
                          input string tag);
        strobe(v);
        for (int i = 0; i < 10; i++) begin
            chk({tag, "_active"}, {63'd0, Highlight_Active}, (i < 8) ? 64'd1 : 64'd0);
            chk({tag, "_mask"}, {56'd0, Change_Mask}, (i < 8) ? {56'd0, m} : 64'd0);
            if (i >= 1) begin
                chk({tag, "_hex"}, {8'd0, hex_all},
                    {8'd0, blink(lit, (i <= 8) ? m : 8'h00, i <= 8)});
            end
            step();
        end
    endtask

    initial begin
        vecs[0]  = '{32'h000000A5, 1'b1, 1'b0, 8'h03, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
        vecs[1]  = '{32'h000001A5, 1'b1, 1'b0, 8'h04, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h08, 7'h12}};
        vecs[2]  = '{32'hDEADBEEF, 1'b1, 1'b1, 8'h00, 1'b0,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h08, 7'h12}};
        vecs[3]  = '{32'hDEADBEEF, 1'b1, 1'b0, 8'hFF, 1'b1,
                     {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[4]  = '{32'h00000000, 1'b1, 1'b0, 8'hFF, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[5]  = '{32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[6]  = '{32'h00000000, 1'b0, 1'b0, 8'h00, 1'b0,
                     {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[7]  = '{32'h12345678, 1'b0, 1'b0, 8'hFF, 1'b1,
                     {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[8]  = '{32'h9ABC0000, 1'b1, 1'b0, 8'hFF, 1'b1,
                     {7'h10, 7'h08, 7'h03, 7'h46, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[9]  = '{32'h9ABC00D0, 1'b1, 1'b0, 8'h02, 1'b1,
                     {7'h10, 7'h08, 7'h03, 7'h46, 7'h40, 7'h40, 7'h21, 7'h40}};
        vecs[10] = '{32'h0000F000, 1'b1, 1'b0, 8'hFA, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40}};
        vecs[11] = '{32'h0000F000, 1'b0, 1'b1, 8'h00, 1'b0,
                     {7'h40, 7'h40, 7'h40, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h40}};
        vecs[12] = '{32'h00000010, 1'b1, 1'b0, 8'h0A, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}};

        // Reset state, then reset asserted in the middle of a highlight
        step();
        step();
        chk("rst_hex", {8'd0, hex_all}, {8'd0, {8{7'h7F}}});
        chk("rst_mask", {56'd0, Change_Mask}, 64'd0);
        chk("rst_active", {63'd0, Highlight_Active}, 64'd0);
        Reset = 1'b0;
        step();
        strobe(32'h00000012);
        step();
        chk("pre_rst_active", {63'd0, Highlight_Active}, 64'd1);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_hex", {8'd0, hex_all}, {8'd0, {8{7'h7F}}});
        chk("mid_rst_mask", {56'd0, Change_Mask}, 64'd0);
        chk("mid_rst_active", {63'd0, Highlight_Active}, 64'd0);
        step();
        Reset = 1'b0;
        Blank_Leading_Zeros = 1'b0;
        step();
        chk("post_rst_hex", {8'd0, hex_all}, {8'd0, {8{7'h40}}});
        chk("post_rst_mask", {56'd0, Change_Mask}, 64'd0);
        chk("post_rst_active", {63'd0, Highlight_Active}, 64'd0);

        // Table: each record starts and ends with the highlight idle
        for (int r = 0; r < 13; r++) begin
            Blank_Leading_Zeros = vecs[r].blank;
            Freeze              = vecs[r].freeze;
            strobe(vecs[r].value);
            Freeze = 1'b0;
            chk($sformatf("vec%0d_mask", r), {56'd0, Change_Mask}, {56'd0, vecs[r].mask});
            chk($sformatf("vec%0d_active", r), {63'd0, Highlight_Active},
                {63'd0, vecs[r].active});
            step();
            chk($sformatf("vec%0d_hex", r), {8'd0, hex_all},
                {8'd0, blink(vecs[r].hex, vecs[r].mask, vecs[r].active)});
            repeat (8) step();
            chk($sformatf("vec%0d_idle_active", r), {63'd0, Highlight_Active}, 64'd0);
            chk($sformatf("vec%0d_idle_mask", r), {56'd0, Change_Mask}, 64'd0);
            chk($sformatf("vec%0d_idle_hex", r), {8'd0, hex_all}, {8'd0, vecs[r].hex});
        end

        // Highlight length and blink phase over a full window
        window(32'h000000A5, 8'h03,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}, "len");

        // Second capture during a highlight replaces the mask and reloads the timer
        strobe(32'h00000000);
        repeat (10) step();
        strobe(32'h000000A5);
        for (int i = 0; i < 3; i++) begin
            chk("repl_first_active", {63'd0, Highlight_Active}, 64'd1);
            chk("repl_first_mask", {56'd0, Change_Mask}, 64'h03);
            step();
        end
        window(32'h000001A5, 8'h04,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h08, 7'h12}, "repl");

        // Capture on the expiry cycle keeps the highlight without a gap
        strobe(32'h00000123);
        for (int i = 0; i < 8; i++) begin
            chk("expiry_first_active", {63'd0, Highlight_Active}, 64'd1);
            if (i < 7) step();
        end
        window(32'h00000321, 8'h05,
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h24, 7'h79}, "expiry");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
